mac_tx_arbiter: RTL and testbench
=================================

Name: mac_tx_arbiter

Overview:
- Shares the single 128-bit MAC transmit path between N_REQ on-chip requesters (e.g. block announcer, transaction relay, status beacon).
- Grants requesters round-robin, one 128-bit word per grant; each word becomes one Ethernet frame.
- Paces grants with a minimum inter-word gap so the unflow-controlled TX clock-crossing FIFO (write-full not monitored) is never overrun by the slower PHY side.
- Sits in the core clock domain, directly upstream of the MAC wrapper tx_data_i/tx_valid_i inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 128, payload word width.
- GAP_CYCLES, 400, minimum clk cycles between successive accepts (>=1; 1 = back-to-back).
- CNT_W, 16, width of per-requester sent counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- enable_i  in  1  when low, no new grants are issued; a running gap still counts down.
- req_data_i  in  N_REQ*DATA_W  requester words; requester k occupies bits [k*DATA_W +: DATA_W].
- req_valid_i  in  N_REQ  requester k has a word pending; must stay high with stable data until accepted.
- req_ready_o  out  N_REQ  one-hot or zero; transfer on valid&ready.
- tx_data_o  out  DATA_W  word to the MAC wrapper tx_data_i.
- tx_valid_o  out  1  one-cycle strobe to the MAC wrapper tx_valid_i.
- busy_o  out  1  gap counter nonzero.
- sent_cnt_o  out  N_REQ*CNT_W  per-requester accepted-word counters.

Behaviour:
- Reset values (async, immediate): tx_valid_o=0, tx_data_o=0, gap counter=0, sent counters=0, last-grant pointer=N_REQ-1 (requester 0 is highest priority after reset), busy_o=0.
- Eligibility: the arbiter may grant only when gap_cnt==0 and enable_i=1.
- Grant is combinational:
  - Select the first requester with valid=1, searching from last_grant+1 upward and wrapping modulo N_REQ.
  - req_ready_o = onehot(selected) when eligible, else 0.
  - req_ready_o never depends on the granted requester's own valid being deasserted in the same cycle.
- Accept at cycle T (valid&ready for requester g):
  - last_grant<=g.
  - tx_data_o<=req_data_i[g]; tx_valid_o=1 during cycle T+1 only.
  - gap_cnt<=GAP_CYCLES-1.
  - sent_cnt[g]<=sent_cnt[g]+1, wrapping 2^CNT_W-1 -> 0.
- Latency: accept to tx_valid_o is 1 cycle. tx_data_o holds its value until the next accept.
- Gap counting:
  - While gap_cnt!=0, it decrements every cycle regardless of enable_i.
  - The next accept is possible at the earliest at T+GAP_CYCLES.
  - GAP_CYCLES=1 allows one accept per cycle.
- Implicit states:
  - IDLE: gap_cnt==0, no valid or enable_i=0.
  - GRANT: gap_cnt==0, enable_i=1, any valid.
  - HOLD: gap_cnt!=0.
  - Transitions: GRANT->HOLD on accept (GRANT->GRANT if GAP_CYCLES=1); HOLD->IDLE/GRANT when gap_cnt reaches 0.
- Boundary conditions:
  - All requesters valid simultaneously: strict rotation 0,1,2,3,0,... with no requester starved beyond N_REQ-1 grants.
  - Single requester valid: it is granted every GAP_CYCLES cycles; the pointer still updates.
  - Requester deasserts valid before being granted: protocol violation. The bench flags it; the design need not handle it.
  - enable_i falling during HOLD: the gap completes, then no grant is issued.
  - enable_i falling on the same cycle as a would-be grant: no grant is issued.
  - Reset mid-gap or on the cycle after an accept: tx_valid_o drops immediately; the pending strobe is lost.
  - sent_cnt wrap is silent; there is no saturation.

Decomposition:
- Package mac_pkg: DATA_W, default GAP_CYCLES, LOC_MAC/EXT_MAC/ETHERTYPE constants, and the function clog2-based GAP_W=$clog2(GAP_CYCLES).
- Sub-module rr_arbiter: parameterised N, inputs req[N] and last_grant pointer, outputs onehot grant plus encoded index; purely combinational.
- mac_tx_arbiter holds the pointer, gap counter, output register and stats.

Test Plan:
- Reset release, req_valid=4'b0001, GAP_CYCLES=4 -> accepts at cycles 0,4,8; tx_valid_o pulses at 1,5,9 with req0 data; sent_cnt0=3 after 3 accepts.
- req_valid=4'b1111 held, distinct data per requester -> tx_data_o sequence req0,req1,req2,req3,req0; each sent_cnt=1 after the first four accepts.
- last_grant=2, req_valid=4'b0011 -> req0 granted next (wrap), then req1.
- enable_i=0 for 20 cycles with req_valid=4'b0100 -> req_ready_o=0 and tx_valid_o=0 throughout; enable_i=1 -> req2 accepted the same cycle, tx_valid_o next cycle.
- Assert reset 2 cycles into a gap -> tx_valid_o=0, busy_o=0, counters 0 asynchronously; after release with all valid, req0 granted first.
- Force sent_cnt1 to 0xFFFF (1 short of wrap via 65535 grants or backdoor) and accept req1 -> sent_cnt1=0x0000.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants for the MAC transmit path: default widths, gap pacing
// and the fixed frame header fields used by the on-chip requesters.
package mac_pkg;

  localparam int MAC_DATA_W     = 128;
  localparam int MAC_GAP_CYCLES = 400;

  localparam logic [47:0] LOC_MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] EXT_MAC   = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] ETHERTYPE = 16'h88B5;

  // The gap counter holds at most gap_cycles-1; keep at least one bit so
  // back-to-back operation (gap_cycles=1) still has a legal vector.
  function automatic int gap_w(input int gap_cycles);
    return (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after
// last_grant, wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last_grant) + i) % N;
      if (!grant_any && req[k]) begin
        grant_any = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Shares the MAC TX word path between N_REQ requesters, round-robin, one
// word per grant, with a minimum gap between accepts to pace the TX FIFO.
//   state | meaning
//   IDLE  | gap_cnt==0, nothing valid or enable_i low
//   GRANT | gap_cnt==0, enable_i high, some requester valid
//   HOLD  | gap_cnt!=0, counting down regardless of enable_i
module mac_tx_arbiter
  import mac_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = MAC_DATA_W,
  parameter int GAP_CYCLES = MAC_GAP_CYCLES,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic                    tx_valid_o,
  output logic                    busy_o,
  output logic [N_REQ*CNT_W-1:0]  sent_cnt_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = gap_w(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant_oh;
  logic             grant_any;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] sent_cnt [N_REQ];
  logic             eligible;
  logic             accept;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant),
    .grant      (grant_oh),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  assign eligible    = (gap_cnt == '0) && enable_i;
  assign accept      = eligible && grant_any;
  assign req_ready_o = eligible ? grant_oh : '0;
  assign busy_o      = (gap_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      gap_cnt    <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      for (int k = 0; k < N_REQ; k++) sent_cnt[k] <= '0;
    end else begin
      tx_valid_o <= accept;
      if (accept) begin
        last_grant          <= grant_idx;
        tx_data_o           <= req_data_i[int'(grant_idx)*DATA_W +: DATA_W];
        gap_cnt             <= GAP_RELOAD;
        // wraps silently at 2^CNT_W
        sent_cnt[grant_idx] <= sent_cnt[grant_idx] + CNT_W'(1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
    assign sent_cnt_o[k*CNT_W +: CNT_W] = sent_cnt[k];
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: per-cycle vector table on a GAP=4
// instance plus a back-to-back instance used for the sent counter wrap.
module tb_mac_tx_arbiter;
  import mac_pkg::*;

  localparam int N = 4;
  localparam int DW = 128;
  localparam int CW = 16;
  localparam int Z = 4;  // src index meaning "tx_data still at reset value"

  typedef struct {
    logic            rst;
    logic            en;
    logic [N-1:0]    valid;
    logic [N-1:0]    rdy;
    logic            txv;
    logic            busy;
    int              src;
    logic [N*CW-1:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en;
  logic [N-1:0]      valid, ready;
  logic [N*DW-1:0]   req_data;
  logic [DW-1:0]     tx_data;
  logic              tx_valid, busy;
  logic [N*CW-1:0]   sent_cnt;

  logic              rst2, en2;
  logic [N-1:0]      valid2, ready2;
  logic [DW-1:0]     tx_data2;
  logic              tx_valid2, busy2;
  logic [N*CW-1:0]   sent_cnt2;

  mac_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(rst), .enable_i(en), .req_data_i(req_data),
    .req_valid_i(valid), .req_ready_o(ready), .tx_data_o(tx_data),
    .tx_valid_o(tx_valid), .busy_o(busy), .sent_cnt_o(sent_cnt)
  );

  mac_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(1), .CNT_W(CW)) dut_b2b (
    .clk(clk), .reset(rst2), .enable_i(en2), .req_data_i(req_data),
    .req_valid_i(valid2), .req_ready_o(ready2), .tx_data_o(tx_data2),
    .tx_valid_o(tx_valid2), .busy_o(busy2), .sent_cnt_o(sent_cnt2)
  );

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];
  logic [N-1:0] prev_valid = '0;
  logic [N-1:0] prev_acc = '0;
  logic         prev_rst = 1'b1;

  function automatic logic [DW-1:0] word(input int k);
    if (k >= N) return '0;
    return {LOC_MAC, EXT_MAC, ETHERTYPE, 16'hA000 + 16'(k)};
  endfunction

  function automatic logic [N*CW-1:0] c(input int c0, input int c1, input int c2, input int c3);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  task automatic rep(input int n, input logic r, input logic e, input logic [N-1:0] v,
                     input logic [N-1:0] rd, input logic tv, input logic b, input int s,
                     input logic [N*CW-1:0] cn);
    vec_t x;
    x.rst = r; x.en = e; x.valid = v; x.rdy = rd; x.txv = tv; x.busy = b; x.src = s; x.cnt = cn;
    for (int i = 0; i < n; i++) tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; drives one cycle and checks mid-cycle.
  task automatic apply(input vec_t v, input int idx);
    logic viol;
    viol = |(prev_valid & ~prev_acc & ~v.valid);
    if (!v.rst && !prev_rst) chk($sformatf("row%0d proto_valid_drop", idx), DW'(viol), '0);
    rst = v.rst; en = v.en; valid = v.valid;
    @(negedge clk);
    chk($sformatf("row%0d ready", idx), DW'(ready), DW'(v.rdy));
    chk($sformatf("row%0d tx_valid", idx), DW'(tx_valid), DW'(v.txv));
    chk($sformatf("row%0d busy", idx), DW'(busy), DW'(v.busy));
    chk($sformatf("row%0d tx_data", idx), tx_data, word(v.src));
    chk($sformatf("row%0d sent_cnt", idx), DW'(sent_cnt), DW'(v.cnt));
    prev_valid = v.valid;
    prev_acc   = v.valid & ready;
    prev_rst   = v.rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = word(k);
    rst = 1'b1; en = 1'b0; valid = '0;
    rst2 = 1'b1; en2 = 1'b0; valid2 = '0;

    // single requester, gap 4: accepts at rows 0,4,8
    rep(1, 0,1,4'b0001, 4'b0001,0,0,Z, c(0,0,0,0));
    rep(1, 0,1,4'b0001, 4'b0000,1,1,0, c(1,0,0,0));
    rep(2, 0,1,4'b0001, 4'b0000,0,1,0, c(1,0,0,0));
    rep(1, 0,1,4'b0001, 4'b0001,0,0,0, c(1,0,0,0));
    rep(1, 0,1,4'b0001, 4'b0000,1,1,0, c(2,0,0,0));
    rep(2, 0,1,4'b0001, 4'b0000,0,1,0, c(2,0,0,0));
    rep(1, 0,1,4'b0001, 4'b0001,0,0,0, c(2,0,0,0));
    rep(1, 0,1,4'b0000, 4'b0000,1,1,0, c(3,0,0,0));
    rep(2, 0,1,4'b0000, 4'b0000,0,1,0, c(3,0,0,0));
    rep(1, 0,1,4'b0000, 4'b0000,0,0,0, c(3,0,0,0));
    rep(1, 1,0,4'b0000, 4'b0000,0,0,Z, c(0,0,0,0));
    // all valid: strict rotation 0,1,2,3,0
    rep(1, 0,1,4'b1111, 4'b0001,0,0,Z, c(0,0,0,0));
    rep(1, 0,1,4'b1111, 4'b0000,1,1,0, c(1,0,0,0));
    rep(2, 0,1,4'b1111, 4'b0000,0,1,0, c(1,0,0,0));
    rep(1, 0,1,4'b1111, 4'b0010,0,0,0, c(1,0,0,0));
    rep(1, 0,1,4'b1111, 4'b0000,1,1,1, c(1,1,0,0));
    rep(2, 0,1,4'b1111, 4'b0000,0,1,1, c(1,1,0,0));
    rep(1, 0,1,4'b1111, 4'b0100,0,0,1, c(1,1,0,0));
    rep(1, 0,1,4'b1111, 4'b0000,1,1,2, c(1,1,1,0));
    rep(2, 0,1,4'b1111, 4'b0000,0,1,2, c(1,1,1,0));
    rep(1, 0,1,4'b1111, 4'b1000,0,0,2, c(1,1,1,0));
    rep(1, 0,1,4'b1111, 4'b0000,1,1,3, c(1,1,1,1));
    rep(2, 0,1,4'b1111, 4'b0000,0,1,3, c(1,1,1,1));
    rep(1, 0,1,4'b1111, 4'b0001,0,0,3, c(1,1,1,1));
    rep(1, 0,1,4'b1111, 4'b0000,1,1,0, c(2,1,1,1));
    // reset two cycles into the gap, then req0 first again
    rep(1, 1,0,4'b1111, 4'b0000,0,0,Z, c(0,0,0,0));
    rep(1, 0,1,4'b1111, 4'b0001,0,0,Z, c(0,0,0,0));
    // reset on the cycle after an accept: pending strobe is lost
    rep(1, 1,0,4'b0000, 4'b0000,0,0,Z, c(0,0,0,0));
    // park pointer on 2, then 0011 wraps to req0, then req1
    rep(1, 0,1,4'b0100, 4'b0100,0,0,Z, c(0,0,0,0));
    rep(1, 0,1,4'b0011, 4'b0000,1,1,2, c(0,0,1,0));
    rep(2, 0,1,4'b0011, 4'b0000,0,1,2, c(0,0,1,0));
    rep(1, 0,1,4'b0011, 4'b0001,0,0,2, c(0,0,1,0));
    rep(1, 0,1,4'b0010, 4'b0000,1,1,0, c(1,0,1,0));
    rep(2, 0,1,4'b0010, 4'b0000,0,1,0, c(1,0,1,0));
    rep(1, 0,1,4'b0010, 4'b0010,0,0,0, c(1,0,1,0));
    // enable drops during HOLD: gap finishes, no grant afterwards
    rep(1, 0,0,4'b0000, 4'b0000,1,1,1, c(1,1,1,0));
    rep(2, 0,0,4'b0000, 4'b0000,0,1,1, c(1,1,1,0));
    rep(20, 0,0,4'b0100, 4'b0000,0,0,1, c(1,1,1,0));
    rep(1, 0,1,4'b0100, 4'b0100,0,0,1, c(1,1,1,0));
    rep(1, 0,1,4'b0000, 4'b0000,1,1,2, c(1,1,2,0));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // back-to-back instance: req1 alone, walk its counter through the wrap
    rst2 = 1'b0; en2 = 1'b1; valid2 = 4'b0010;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      if (i < 3) begin
        chk($sformatf("b2b%0d ready", i), DW'(ready2), DW'(4'b0010));
        chk($sformatf("b2b%0d busy", i), DW'(busy2), '0);
        chk($sformatf("b2b%0d sent_cnt", i), DW'(sent_cnt2), DW'(c(0,i,0,0)));
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("b2b pre_wrap sent_cnt", DW'(sent_cnt2), DW'(c(0,16'hFFFF,0,0)));
    chk("b2b tx_valid", DW'(tx_valid2), DW'(1'b1));
    chk("b2b tx_data", tx_data2, word(1));
    @(posedge clk);
    #1;
    valid2 = '0;
    @(negedge clk);
    chk("b2b wrap sent_cnt", DW'(sent_cnt2), DW'(c(0,0,0,0)));
    chk("b2b last tx_valid", DW'(tx_valid2), DW'(1'b1));
    @(negedge clk);
    chk("b2b idle tx_valid", DW'(tx_valid2), '0);
    chk("b2b idle ready", DW'(ready2), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
